// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared encodings for the register-file write-back unit.
//   wb_sel_t  : write-back data source (ALU result, memory data, link address)
//   dst_sel_t : destination register field (rt, rd, or the link register)
//   LINK_REG  : architectural link register index (r31); the low ADDR_W bits
//               of it map to NREGS-1 on smaller register files.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        DST_RT   = 2'd0,
        DST_RD   = 2'd1,
        DST_RA   = 2'd2,
        DST_RSVD = 2'd3
    } dst_sel_t;

    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/regfile_array.sv
// -----------------------------------------------------------------------------
// regfile_array
// DATA_W x NREGS register storage.
//   clk, rst            : clock, asynchronous active-high reset (clears all)
//   we, waddr, wdata    : synchronous write port
//   raddr_a/b, rdata_a/b: asynchronous read ports; index 0 always reads 0
//   dbg_addr, dbg_data  : synchronous debug read port, one cycle latency
// -----------------------------------------------------------------------------
module regfile_array #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // NOTE: every entry is cleared on reset, so this storage builds from
    // flops, not RAM; the register file must read all-zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            dbg_data <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            dbg_data <= mem[dbg_addr];
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/regfile_wb_unit.sv
// -----------------------------------------------------------------------------
// regfile_wb_unit
// Register-file write-back unit for the multi-cycle CPU datapath.
//   clk, rst            : clock, asynchronous active-high reset
//   ir_data             : instruction register (rs=[25:21] rt=[20:16] rd=[15:11])
//   c_data/dr_data/pc_data : ALU, memory and link write-back sources
//   wb_sel, dst_sel     : write-back source / destination selects
//   write_reg           : write strobe
//   rdata_A, rdata_B    : combinational reads of rs, rt
//   wb_pending          : staging entry holds a write not yet in the array
//   dbg_auto, dbg_sel   : debug index mode (auto-scan / follow switches)
//   dbg_idx, dbg_data   : current debug index and its registered contents
// Build option: define REGFILE_WB_BYPASS_EN to forward the staged write to
// rdata_A/rdata_B; without it the control FSM waits for wb_pending=0.
// -----------------------------------------------------------------------------
module regfile_wb_unit
    import regfile_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          NREGS   = 32,
    // Dwell per register in auto-scan, in clk cycles (1 s at 50 MHz); >= 1.
    parameter int unsigned DBG_DIV = 32'd50_000_000,
    localparam int         ADDR_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ir_data,
    input  logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] dr_data,
    input  logic [DATA_W-1:0] pc_data,
    input  logic [1:0]        wb_sel,
    input  logic [1:0]        dst_sel,
    input  logic              write_reg,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic              wb_pending,
    input  logic              dbg_auto,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [ADDR_W-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int              CNT_W    = (DBG_DIV > 1) ? $clog2(DBG_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBG_DIV - 1);

    // Register index decode: low ADDR_W bits of each 5-bit field.
    logic [ADDR_W-1:0] rs, rt, rd;
    assign rs = ir_data[21 +: ADDR_W];
    assign rt = ir_data[16 +: ADDR_W];
    assign rd = ir_data[11 +: ADDR_W];

    // Opcode/funct bits are not used here; reduced to keep the port complete.
    logic unused_ir;
    assign unused_ir = ^ir_data;

    wb_sel_t  wb_mode;
    dst_sel_t dst_mode;
    assign wb_mode  = wb_sel_t'(wb_sel);
    assign dst_mode = dst_sel_t'(dst_sel);

    // Write-back source/destination selection.
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_num;
    logic              wr_ok;

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_data = c_data;
        wr_num  = rt;
        wr_ok   = 1'b1;
        case (wb_mode)
            WB_ALU:  wr_data = c_data;
            WB_MEM:  wr_data = dr_data;
            WB_LINK: wr_data = pc_data;
            default: wr_ok   = 1'b0;
        endcase
        case (dst_mode)
            DST_RT:  wr_num = rt;
            DST_RD:  wr_num = rd;
            DST_RA:  wr_num = ADDR_W'(LINK_REG);
            default: wr_ok  = 1'b0;
        endcase
        // r0 is hard-wired zero: such writes never enter the staging entry.
        if (wr_num == '0) begin
            wr_ok = 1'b0;
        end
    end

    // One-entry staging register; its contents commit on the following edge.
    logic              pend_v;
    logic [ADDR_W-1:0] pend_num;
    logic [DATA_W-1:0] pend_data;
    logic              accept;
    assign accept = write_reg && wr_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_num  <= '0;
            pend_data <= '0;
        end else begin
            pend_v <= accept;
            if (accept) begin
                pend_num  <= wr_num;
                pend_data <= wr_data;
            end
        end
    end

    assign wb_pending = pend_v;

    logic [DATA_W-1:0] arr_a, arr_b;

    regfile_array #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .we       (pend_v),
        .waddr    (pend_num),
        .wdata    (pend_data),
        .raddr_a  (rs),
        .raddr_b  (rt),
        .rdata_a  (arr_a),
        .rdata_b  (arr_b),
        .dbg_addr (dbg_idx),
        .dbg_data (dbg_data)
    );

    always_comb begin
        rdata_A = arr_a;
        rdata_B = arr_b;
`ifdef REGFILE_WB_BYPASS_EN
        if (pend_v && pend_num == rs && rs != '0) begin
            rdata_A = pend_data;
        end
        if (pend_v && pend_num == rt && rt != '0) begin
            rdata_B = pend_data;
        end
`endif
    end

    // Debug scan: dwell counter plus index. Manual mode tracks the switches
    // and holds the counter at zero; auto mode resumes from the current index.
    logic [CNT_W-1:0]  dwell_cnt, dwell_cnt_nxt;
    logic [ADDR_W-1:0] dbg_idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            dbg_idx   <= '0;
        end else begin
            dwell_cnt <= dwell_cnt_nxt;
            dbg_idx   <= dbg_idx_nxt;
        end
    end

    always_comb begin
        dwell_cnt_nxt = '0;
        dbg_idx_nxt   = dbg_sel;
        if (dbg_auto) begin
            if (dwell_cnt == CNT_LAST) begin
                dwell_cnt_nxt = '0;
                // NREGS is a power of two, so the increment wraps to 0.
                dbg_idx_nxt   = dbg_idx + ADDR_W'(1);
            end else begin
                dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
                dbg_idx_nxt   = dbg_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_unit
// Scoreboard bench for regfile_wb_unit. Two instances share all inputs:
// NREGS=32 and NREGS=16, both with DBG_DIV=4. Stimulus pushes the expected
// value of one output for the current cycle; a monitor pops and compares on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_unit;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_RA     = 0;
    localparam int S_RB     = 1;
    localparam int S_PEND   = 2;
    localparam int S_IDX    = 3;
    localparam int S_DDATA  = 4;
    localparam int S_RA16   = 5;
    localparam int S_IDX16  = 6;
    localparam int S_PEND16 = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_data, c_data, dr_data, pc_data;
    logic [1:0]  wb_sel, dst_sel;
    logic        write_reg, dbg_auto;
    logic [4:0]  dbg_sel;

    logic [31:0] rdata_A, rdata_B, dbg_data;
    logic        wb_pending;
    logic [4:0]  dbg_idx;

    logic [31:0] rdata_A16, rdata_B16, dbg_data16;
    logic        wb_pending16;
    logic [3:0]  dbg_idx16;

    regfile_wb_unit #(.DATA_W(32), .NREGS(32), .DBG_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .ir_data(ir_data), .c_data(c_data),
        .dr_data(dr_data), .pc_data(pc_data), .wb_sel(wb_sel),
        .dst_sel(dst_sel), .write_reg(write_reg), .rdata_A(rdata_A),
        .rdata_B(rdata_B), .wb_pending(wb_pending), .dbg_auto(dbg_auto),
        .dbg_sel(dbg_sel), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    regfile_wb_unit #(.DATA_W(32), .NREGS(16), .DBG_DIV(4)) u_dut16 (
        .clk(clk), .rst(rst), .ir_data(ir_data), .c_data(c_data),
        .dr_data(dr_data), .pc_data(pc_data), .wb_sel(wb_sel),
        .dst_sel(dst_sel), .write_reg(write_reg), .rdata_A(rdata_A16),
        .rdata_B(rdata_B16), .wb_pending(wb_pending16), .dbg_auto(dbg_auto),
        .dbg_sel(dbg_sel[3:0]), .dbg_idx(dbg_idx16), .dbg_data(dbg_data16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_RA:     return rdata_A;
            S_RB:     return rdata_B;
            S_PEND:   return {31'd0, wb_pending};
            S_IDX:    return {27'd0, dbg_idx};
            S_DDATA:  return dbg_data;
            S_RA16:   return rdata_A16;
            S_IDX16:  return {28'd0, dbg_idx16};
            S_PEND16: return {31'd0, wb_pending16};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Expectation for the current cycle, compared at the next falling edge.
    task automatic want(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        e.due  = cyc;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check(e.name, sample(e.sig), e.exp);
            end
        end
    end

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    initial begin
        rst = 1'b1; write_reg = 1'b0; wb_sel = 2'd0; dst_sel = 2'd0;
        ir_data = mk_ir(5, 5, 5); c_data = '0; dr_data = '0; pc_data = '0;
        dbg_auto = 1'b0; dbg_sel = 5'd0;
        tick(); tick();

        // Reset state
        want("rst_ra", S_RA, 32'h0);
        want("rst_rb", S_RB, 32'h0);
        want("rst_pend", S_PEND, 32'h0);
        want("rst_idx", S_IDX, 32'h0);
        want("rst_ddata", S_DDATA, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Reset while a write is staged
        ir_data = mk_ir(5, 0, 5); dst_sel = 2'd1; wb_sel = 2'd0;
        c_data = 32'hDEAD_BEEF; write_reg = 1'b1;
        want("t1_pend_pre", S_PEND, 32'h0);
        tick();
        write_reg = 1'b0;
        want("t1_pend", S_PEND, 32'h1);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        want("t1_pend_rst", S_PEND, 32'h0);
        want("t1_r5_rst", S_RA, 32'h0);
        rst = 1'b0;
        tick();
        want("t1_r5_after", S_RA, 32'h0);
        want("t1_pend_after", S_PEND, 32'h0);
        tick();
        want("t1_r5_late", S_RA, 32'h0);
        tick();

        // 2. ALU write to rd
        ir_data = mk_ir(3, 0, 3); dst_sel = 2'd1; wb_sel = 2'd0;
        c_data = 32'h1234_5678; write_reg = 1'b1;
        want("t2_pend_n", S_PEND, 32'h0);
        tick();
        write_reg = 1'b0; c_data = '0;
        want("t2_pend_n1", S_PEND, 32'h1);
        want("t2_ra_n1", S_RA, BYP ? 32'h1234_5678 : 32'h0);
        tick();
        want("t2_pend_n2", S_PEND, 32'h0);
        want("t2_ra_n2", S_RA, 32'h1234_5678);
        tick();

        // 3. MEM write to rt, read in the staging cycle
        ir_data = mk_ir(0, 7, 0); dst_sel = 2'd0; wb_sel = 2'd1;
        dr_data = 32'hCAFE_0001; write_reg = 1'b1;
        tick();
        write_reg = 1'b0;
        want("t3_rb_n1", S_RB, BYP ? 32'hCAFE_0001 : 32'h0);
        want("t3_pend_n1", S_PEND, 32'h1);
        tick();
        want("t3_rb_n2", S_RB, 32'hCAFE_0001);
        want("t3_pend_n2", S_PEND, 32'h0);
        tick();

        // Write to r0 is dropped
        ir_data = mk_ir(0, 0, 0); dst_sel = 2'd1; wb_sel = 2'd0;
        c_data = 32'hFFFF_FFFF; write_reg = 1'b1;
        tick();
        write_reg = 1'b0;
        want("t3_r0_pend", S_PEND, 32'h0);
        want("t3_r0_ra", S_RA, 32'h0);
        tick();
        want("t3_r0_pend2", S_PEND, 32'h0);
        want("t3_r0_ra2", S_RA, 32'h0);
        tick();

        // Reserved wb_sel, then reserved dst_sel: both dropped, r7 untouched
        ir_data = mk_ir(0, 7, 7); dst_sel = 2'd1; wb_sel = 2'd3;
        c_data = 32'h5555_5555; dr_data = 32'hAAAA_AAAA; write_reg = 1'b1;
        tick();
        wb_sel = 2'd0; dst_sel = 2'd3;
        want("t3_wbrsv_pend", S_PEND, 32'h0);
        tick();
        write_reg = 1'b0; dst_sel = 2'd0;
        want("t3_dstrsv_pend", S_PEND, 32'h0);
        want("t3_rsv_r7", S_RB, 32'hCAFE_0001);
        tick();
        want("t3_rsv_r7b", S_RB, 32'hCAFE_0001);
        tick();

        // 4. Back-to-back writes
        dst_sel = 2'd1; wb_sel = 2'd0;
        ir_data = mk_ir(0, 0, 4); c_data = 32'h1; write_reg = 1'b1;
        want("t4_pend_0", S_PEND, 32'h0);
        tick();
        c_data = 32'h2;
        want("t4_pend_1", S_PEND, 32'h1);
        tick();
        ir_data = mk_ir(0, 0, 9); c_data = 32'h3;
        want("t4_pend_2", S_PEND, 32'h1);
        tick();
        write_reg = 1'b0; ir_data = mk_ir(4, 9, 0);
        want("t4_pend_3", S_PEND, 32'h1);
        want("t4_pend16_3", S_PEND16, 32'h1);
        tick();
        want("t4_pend_4", S_PEND, 32'h0);
        want("t4_r4", S_RA, 32'h2);
        want("t4_r9", S_RB, 32'h3);
        want("t4_r4_16", S_RA16, 32'h2);
        tick();

        // 5. Link write to r31 (r15 on the 16-entry file)
        ir_data = mk_ir(0, 0, 0); dst_sel = 2'd2; wb_sel = 2'd2;
        pc_data = 32'h0000_0040; write_reg = 1'b1;
        tick();
        write_reg = 1'b0; dst_sel = 2'd0; wb_sel = 2'd0;
        ir_data = mk_ir(31, 30, 0);
        tick();
        want("t5_r31", S_RA, 32'h40);
        want("t5_r30", S_RB, 32'h0);
        want("t5_r15_16", S_RA16, 32'h40);
        tick();

        // 6. Debug auto-scan, DBG_DIV=4, starting from index 0
        dbg_auto = 1'b1;
        for (int k = 0; k < 132; k++) begin
            want($sformatf("t6_idx_k%0d", k), S_IDX, 32'((k / 4) % 32));
            want($sformatf("t6_idx16_k%0d", k), S_IDX16, 32'((k / 4) % 16));
            tick();
        end
        dbg_auto = 1'b0; dbg_sel = 5'd3;
        tick();
        want("t6_man_idx", S_IDX, 32'h3);
        tick();
        want("t6_man_data", S_DDATA, 32'h1234_5678);
        want("t6_man_idx2", S_IDX, 32'h3);
        tick();

        tick();
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
